// File: rtl/tmds_pkg.sv
// Shared constants and state encoding for the TMDS serializer output stage.
package tmds_pkg;
   localparam int TmdsWordWidth = 10;
   localparam int SerRatio      = 10;
   localparam logic [TmdsWordWidth-1:0] TmdsClkPattern = 10'b0000011111;

   typedef enum logic [1:0] {
      S_WARMUP = 2'd0,
      S_MUTE   = 2'd1,
      S_RUN    = 2'd2
   } phy_state_e;
endpackage

// File: rtl/tmds_lane_shifter.sv
// One TMDS lane: capture register for the pixel-domain word plus a 10-bit
// load/shift register emitting the word LSB-first.
module tmds_lane_shifter
   import tmds_pkg::*;
(
   input  logic                     clk_ser,
   input  logic                     rst_ser,
   input  logic                     cap_en,
   input  logic                     load_en,
   input  logic                     mute,
   input  logic [TmdsWordWidth-1:0] d,
   output logic                     ser
);

   logic [TmdsWordWidth-1:0] cap_q;
   logic [TmdsWordWidth-1:0] shreg_q;

   always_ff @(posedge clk_ser or posedge rst_ser) begin
      if (rst_ser) begin
         cap_q   <= '0;
         shreg_q <= '0;
      end else begin
         if (cap_en)
            cap_q <= d;
         if (load_en)
            shreg_q <= mute ? '0 : cap_q;
         else
            shreg_q <= {1'b0, shreg_q[TmdsWordWidth-1:1]};
      end
   end

   assign ser = shreg_q[0];

endmodule

// File: rtl/tmds_phy_serializer.sv
// DVI output stage: divides clk_ser by 10 into the pixel clock, serializes three
// TMDS data lanes plus the clock lane, and sequences pixel reset / lane muting.
module tmds_phy_serializer
   import tmds_pkg::*;
#(
   parameter logic [3:0] LoadPhase   = 4'd7,
   parameter logic [7:0] WarmupWords = 8'd4,
   parameter logic [7:0] MuteWords   = 8'd2
) (
   input  logic                     clk_ser,
   input  logic                     rst_ser,
   input  logic [TmdsWordWidth-1:0] tmds_0_i,
   input  logic [TmdsWordWidth-1:0] tmds_1_i,
   input  logic [TmdsWordWidth-1:0] tmds_2_i,
   output logic                     clk_pxl_o,
   output logic                     pxl_rst_o,
   output logic [2:0]               ser_o,
   output logic                     ser_clk_o,
   output logic                     running_o
);

   localparam logic [3:0] CntLast  = 4'(SerRatio - 1);
   localparam logic [3:0] CntHalf  = 4'(SerRatio / 2);
   // A warm-up length of zero behaves as a single word period.
   localparam logic [7:0] WarmLast = (WarmupWords == 8'd0) ? 8'd0 : WarmupWords - 8'd1;
   localparam logic [7:0] MuteLast = (MuteWords == 8'd0) ? 8'd0 : MuteWords - 8'd1;

   logic [3:0] cnt_q, cnt_d;
   logic       clk_pxl_q;
   logic       pxl_rst_q, pxl_rst_d;
   phy_state_e state_q, state_d;
   logic [7:0] word_q, word_d;
   logic       cap_en, load_en, mute;

   assign cnt_d   = (cnt_q == CntLast) ? 4'd0 : cnt_q + 4'd1;
   assign load_en = (cnt_q == CntLast);
   assign cap_en  = (cnt_q == LoadPhase);

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      pxl_rst_d = pxl_rst_q;
      if (load_en) begin
         case (state_q)
            S_WARMUP: begin
               if (word_q == WarmLast) begin
                  word_d    = 8'd0;
                  pxl_rst_d = 1'b0;
                  state_d   = (MuteWords == 8'd0) ? S_RUN : S_MUTE;
               end else begin
                  word_d = word_q + 8'd1;
               end
            end
            S_MUTE: begin
               if (word_q == MuteLast) begin
                  word_d  = 8'd0;
                  state_d = S_RUN;
               end else begin
                  word_d = word_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The load edge that enters S_RUN already carries real data.
   assign mute = (state_d != S_RUN);

   always_ff @(posedge clk_ser or posedge rst_ser) begin
      if (rst_ser) begin
         cnt_q     <= 4'd0;
         clk_pxl_q <= 1'b1;
         pxl_rst_q <= 1'b1;
         state_q   <= S_WARMUP;
         word_q    <= 8'd0;
      end else begin
         cnt_q     <= cnt_d;
         clk_pxl_q <= (cnt_d < CntHalf);
         pxl_rst_q <= pxl_rst_d;
         state_q   <= state_d;
         word_q    <= word_d;
      end
   end

   assign clk_pxl_o = clk_pxl_q;
   assign pxl_rst_o = pxl_rst_q;
   assign running_o = (state_q == S_RUN);

   logic [TmdsWordWidth-1:0] tmds_w [3];
   assign tmds_w[0] = tmds_0_i;
   assign tmds_w[1] = tmds_1_i;
   assign tmds_w[2] = tmds_2_i;

   for (genvar k = 0; k < 3; k++) begin : g_lane
      tmds_lane_shifter u_lane (
         .clk_ser (clk_ser),
         .rst_ser (rst_ser),
         .cap_en  (cap_en),
         .load_en (load_en),
         .mute    (mute),
         .d       (tmds_w[k]),
         .ser     (ser_o[k])
      );
   end

   // Clock lane is never muted so the sink locks before data arrives.
   tmds_lane_shifter u_clk_lane (
      .clk_ser (clk_ser),
      .rst_ser (rst_ser),
      .cap_en  (cap_en),
      .load_en (load_en),
      .mute    (1'b0),
      .d       (TmdsClkPattern),
      .ser     (ser_clk_o)
   );

endmodule

// File: tb/tb_tmds_phy_serializer.sv
// Bench for tmds_phy_serializer: per-cycle divider/sequencer model plus a
// word scoreboard fed at each capture edge and drained at each word end.
module tb_tmds_phy_serializer;

   logic       clk_ser = 1'b0;
   logic       rst_ser = 1'b1;
   logic [9:0] t0 = '0, t1 = '0, t2 = '0;
   logic       clk_pxl_o, pxl_rst_o, ser_clk_o, running_o;
   logic [2:0] ser_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [29:0] exp_q [$];
   logic [29:0] exp_w;
   logic [9:0]  obs0, obs1, obs2;
   logic [3:0]  ph;
   logic        word_done;

   tmds_phy_serializer dut (
      .clk_ser   (clk_ser),
      .rst_ser   (rst_ser),
      .tmds_0_i  (t0),
      .tmds_1_i  (t1),
      .tmds_2_i  (t2),
      .clk_pxl_o (clk_pxl_o),
      .pxl_rst_o (pxl_rst_o),
      .ser_o     (ser_o),
      .ser_clk_o (ser_clk_o),
      .running_o (running_o)
   );

   always #5 clk_ser = ~clk_ser;

   // Advance one bit period; push the expected word at each capture edge and
   // collect observed serial bits, sampling on the falling edge.
   task automatic step();
      @(posedge clk_ser);
      if (!rst_ser) begin
         if (cyc % 10 == 7)
            exp_q.push_back((cyc / 10 + 1 <= 5) ? 30'h0 : {t2, t1, t0});
         cyc++;
      end
      @(negedge clk_ser);
      ph = 4'(cyc % 10);
      obs0[ph] = ser_o[0];
      obs1[ph] = ser_o[1];
      obs2[ph] = ser_o[2];
      word_done = (cyc % 10 == 9) && (cyc >= 19);
   endtask

   task automatic test_reset();
      rst_ser = 1'b1;
      repeat (3) @(negedge clk_ser);
      n_checks++; if (clk_pxl_o !== 1'b1) begin n_fail++; $display("FAIL reset_clk_pxl got %b want 1", clk_pxl_o); end
      n_checks++; if (pxl_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_pxl_rst got %b want 1", pxl_rst_o); end
      n_checks++; if (ser_o !== 3'b000) begin n_fail++; $display("FAIL reset_ser got %b want 000", ser_o); end
      n_checks++; if (ser_clk_o !== 1'b0) begin n_fail++; $display("FAIL reset_ser_clk got %b want 0", ser_clk_o); end
      n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running_o); end
      rst_ser = 1'b0;
      cyc = 0;
      exp_q.delete();
   endtask

   // Runs from a reset release: divider, clock lane, sequencing and lane data.
   task automatic test_startup(input int ncyc);
      logic e_pxl, e_rst, e_run, e_sck;
      t0 = 10'b1101010100;
      t1 = 10'h155;
      t2 = 10'h0F0;
      for (int i = 0; i < ncyc; i++) begin
         step();
         e_pxl = (cyc % 10) < 5;
         e_rst = cyc < 40;
         e_run = cyc >= 60;
         e_sck = (cyc >= 10) && ((cyc % 10) < 5);
         n_checks++; if (clk_pxl_o !== e_pxl) begin n_fail++; $display("FAIL clk_pxl cyc=%0d got %b want %b", cyc, clk_pxl_o, e_pxl); end
         n_checks++; if (pxl_rst_o !== e_rst) begin n_fail++; $display("FAIL pxl_rst cyc=%0d got %b want %b", cyc, pxl_rst_o, e_rst); end
         n_checks++; if (running_o !== e_run) begin n_fail++; $display("FAIL running cyc=%0d got %b want %b", cyc, running_o, e_run); end
         n_checks++; if (ser_clk_o !== e_sck) begin n_fail++; $display("FAIL ser_clk cyc=%0d got %b want %b", cyc, ser_clk_o, e_sck); end
         if (word_done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL startup_word period=%0d got %h want queued word", cyc / 10, {obs2, obs1, obs0});
            end else begin
               exp_w = exp_q.pop_front();
               if ({obs2, obs1, obs0} !== exp_w) begin
                  n_fail++; $display("FAIL startup_word period=%0d got %h want %h", cyc / 10, {obs2, obs1, obs0}, exp_w);
               end
            end
         end
      end
   endtask

   // Input change just after (cnt 8) versus just before (cnt 6) the capture edge.
   task automatic test_capture_phase();
      int ph_sel, n_per;
      bit changed;
      for (int c = 0; c < 2; c++) begin
         ph_sel = (c == 0) ? 8 : 6;
         t1 = 10'h3FF;
         changed = 1'b0;
         n_per = 0;
         for (int i = 0; i < 60; i++) begin
            step();
            if (!changed && i >= 20 && (cyc % 10) == ph_sel) begin
               t1 = 10'h000;
               n_per = cyc / 10;
               changed = 1'b1;
            end
            if (word_done) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL capture_word period=%0d got %h want queued word", cyc / 10, {obs2, obs1, obs0});
               end else begin
                  exp_w = exp_q.pop_front();
                  if ({obs2, obs1, obs0} !== exp_w) begin
                     n_fail++; $display("FAIL capture_word period=%0d got %h want %h", cyc / 10, {obs2, obs1, obs0}, exp_w);
                  end
               end
               if (changed && cyc / 10 == n_per + 1) begin
                  n_checks++;
                  if (obs1 !== ((c == 0) ? 10'h3FF : 10'h000)) begin
                     n_fail++; $display("FAIL capture_phase%0d_n1 got %h want %h", ph_sel, obs1, (c == 0) ? 10'h3FF : 10'h000);
                  end
               end
               if (changed && cyc / 10 == n_per + 2) begin
                  n_checks++;
                  if (obs1 !== 10'h000) begin
                     n_fail++; $display("FAIL capture_phase%0d_n2 got %h want 000", ph_sel, obs1);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_lanes();
      int start_per;
      t0 = 10'h2AA;
      t1 = 10'h155;
      t2 = 10'h0F0;
      start_per = cyc / 10;
      for (int i = 0; i < 40; i++) begin
         step();
         if (word_done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL lanes_word period=%0d got %h want queued word", cyc / 10, {obs2, obs1, obs0});
            end else begin
               exp_w = exp_q.pop_front();
               if ({obs2, obs1, obs0} !== exp_w) begin
                  n_fail++; $display("FAIL lanes_word period=%0d got %h want %h", cyc / 10, {obs2, obs1, obs0}, exp_w);
               end
            end
            if (cyc / 10 >= start_per + 2) begin
               n_checks++;
               if ({obs2, obs1, obs0} !== {10'h0F0, 10'h155, 10'h2AA}) begin
                  n_fail++; $display("FAIL lanes_fixed got %h/%h/%h want 0f0/155/2aa", obs2, obs1, obs0);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while ((cyc % 10) != 4 && guard < 20) begin
         step();
         guard++;
      end
      n_checks++; if ((cyc % 10) != 4) begin n_fail++; $display("FAIL mid_reset_align got %0d want 4", cyc % 10); end
      #1 rst_ser = 1'b1;
      #1;
      n_checks++; if (clk_pxl_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_clk_pxl got %b want 1", clk_pxl_o); end
      n_checks++; if (pxl_rst_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pxl_rst got %b want 1", pxl_rst_o); end
      n_checks++; if (ser_o !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ser got %b want 000", ser_o); end
      n_checks++; if (ser_clk_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ser_clk got %b want 0", ser_clk_o); end
      n_checks++; if (running_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_running got %b want 0", running_o); end
      repeat (3) @(posedge clk_ser);
      @(negedge clk_ser);
      rst_ser = 1'b0;
      cyc = 0;
      exp_q.delete();
      test_startup(80);
   endtask

   initial begin
      test_reset();
      test_startup(100);
      test_capture_phase();
      test_lanes();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
